// File: rtl/flight_attendant_call_arbiter.sv
// Round-robin arbiter that shares one flight attendant between per-seat call lights.
// Define CALL_ESCALATE_EN to enable the unanswered-offer escalation timer.
module flight_attendant_call_arbiter #(
    parameter int unsigned NUM_SEATS       = 8,
    parameter int unsigned IDX_W           = $clog2(NUM_SEATS),
    parameter int unsigned ESCALATE_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_SEATS-1:0] call_button,
    input  logic [NUM_SEATS-1:0] cancel_button,
    input  logic                 attendant_ack,
    input  logic                 attendant_done,
    output logic [NUM_SEATS-1:0] light_state,
    output logic                 dispatch_valid,
    output logic [IDX_W-1:0]     dispatch_seat,
    output logic                 busy,
    output logic                 escalate
);

    typedef enum logic [1:0] {
        StIdle,
        StOffer,
        StServicing
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_SEATS-1:0] light_q, light_d;
    logic [NUM_SEATS-1:0] clr;
    logic [IDX_W-1:0]     seat_q, seat_d;
    logic [IDX_W-1:0]     rr_q, rr_d;
    logic [IDX_W-1:0]     seat_after;
    logic [IDX_W-1:0]     pick;
    logic                 pick_found;
    logic                 valid_q, busy_q;

    if (NUM_SEATS < 2 || ESCALATE_CYCLES < 1) begin : gen_cfg_check
        $error("flight_attendant_call_arbiter: NUM_SEATS must be >= 2, ESCALATE_CYCLES >= 1");
    end

    // Call has priority: a seat that presses call on the clearing edge stays lit.
    always_comb begin : light_next
        clr = '0;
        if (state_q == StServicing && attendant_done) begin
            clr[seat_q] = 1'b1;
        end
        light_d = call_button | (light_q & ~cancel_button & ~clr);
    end

    // First lit seat at or after rr_q, wrapping around the cabin.
    always_comb begin : rr_pick
        int unsigned idx;
        pick       = rr_q;
        pick_found = 1'b0;
        idx        = 0;
        for (int unsigned k = 0; k < NUM_SEATS; k++) begin
            idx = (32'(rr_q) + k) % NUM_SEATS;
            if (!pick_found && light_q[IDX_W'(idx)]) begin
                pick_found = 1'b1;
                pick       = IDX_W'(idx);
            end
        end
    end

    assign seat_after = (seat_q == IDX_W'(NUM_SEATS - 1)) ? '0 : seat_q + IDX_W'(1);

    always_comb begin : fsm_next
        state_d = state_q;
        seat_d  = seat_q;
        rr_d    = rr_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    seat_d  = pick;
                    state_d = StOffer;
                end
            end
            StOffer: begin
                // Ack wins over a same-cycle cancel of the offered seat.
                if (attendant_ack) begin
                    state_d = StServicing;
                    rr_d    = seat_after;
                end else if (!light_d[seat_q]) begin
                    state_d = StIdle;
                end
            end
            StServicing: begin
                if (attendant_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            light_q <= '0;
            seat_q  <= '0;
            rr_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            light_q <= light_d;
            seat_q  <= seat_d;
            rr_q    <= rr_d;
            valid_q <= (state_d == StOffer);
            busy_q  <= (state_d == StServicing);
        end
    end

`ifdef CALL_ESCALATE_EN
    localparam int unsigned CNT_W = $clog2(ESCALATE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ESCALATE_CYCLES);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             escalate_q, escalate_d;

    // Counts completed OFFER cycles of the current offer; zero outside OFFER.
    always_comb begin : wait_next
        wait_cnt_d = '0;
        if (state_q == StOffer && state_d == StOffer) begin
            wait_cnt_d = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
        end
        escalate_d = (state_d == StOffer) && (wait_cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
            escalate_q <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            escalate_q <= escalate_d;
        end
    end

    assign escalate = escalate_q;
`else
    assign escalate = 1'b0;
`endif

    assign light_state    = light_q;
    assign dispatch_valid = valid_q;
    assign busy           = busy_q;
    assign dispatch_seat  = seat_q;

endmodule

// File: tb/tb_flight_attendant_call_arbiter.sv
// Bench for flight_attendant_call_arbiter: directed scenarios plus a randomized run
// against a cycle-level reference model of the call/offer/service rules.
module tb_flight_attendant_call_arbiter;

    localparam int NUM_SEATS       = 8;
    localparam int IDX_W           = 3;
    localparam int ESCALATE_CYCLES = 4;
    localparam int OBS_W           = NUM_SEATS + 2 + IDX_W + 1;
`ifdef CALL_ESCALATE_EN
    localparam bit ESC_ON = 1'b1;
`else
    localparam bit ESC_ON = 1'b0;
`endif
    localparam int M_IDLE  = 0;
    localparam int M_OFFER = 1;
    localparam int M_SERV  = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NUM_SEATS-1:0] call_button;
    logic [NUM_SEATS-1:0] cancel_button;
    logic                 attendant_ack;
    logic                 attendant_done;
    logic [NUM_SEATS-1:0] light_state;
    logic                 dispatch_valid;
    logic [IDX_W-1:0]     dispatch_seat;
    logic                 busy;
    logic                 escalate;

    logic [OBS_W-1:0]     obs;
    logic [OBS_W-1:0]     exp;
    int                   checks = 0;
    int                   errors = 0;

    // Reference model state.
    bit [NUM_SEATS-1:0]   m_light;
    int                   m_mode;
    int                   m_seat;
    int                   m_rr;
    int                   m_age;
    bit                   m_esc;

    always #5 clk = ~clk;

    flight_attendant_call_arbiter #(
        .NUM_SEATS       (NUM_SEATS),
        .IDX_W           (IDX_W),
        .ESCALATE_CYCLES (ESCALATE_CYCLES)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .call_button    (call_button),
        .cancel_button  (cancel_button),
        .attendant_ack  (attendant_ack),
        .attendant_done (attendant_done),
        .light_state    (light_state),
        .dispatch_valid (dispatch_valid),
        .dispatch_seat  (dispatch_seat),
        .busy           (busy),
        .escalate       (escalate)
    );

    assign obs = {light_state, dispatch_valid, busy, dispatch_seat, escalate};

    // Applies one clock edge of the rules to the model using the current inputs.
    task automatic model_edge();
        bit [NUM_SEATS-1:0] nl;
        int                 nmode;
        bit                 cleared;
        if (reset) begin
            m_light = '0;
            m_mode  = M_IDLE;
            m_seat  = 0;
            m_rr    = 0;
            m_age   = 0;
            m_esc   = 1'b0;
            return;
        end
        for (int i = 0; i < NUM_SEATS; i++) begin
            cleared = (m_mode == M_SERV) && attendant_done && (m_seat == i);
            nl[i]   = call_button[i] || (m_light[i] && !cancel_button[i] && !cleared);
        end
        nmode = m_mode;
        if (m_mode == M_IDLE && m_light != 0) begin
            for (int k = NUM_SEATS - 1; k >= 0; k--) begin
                if (m_light[(m_rr + k) % NUM_SEATS]) m_seat = (m_rr + k) % NUM_SEATS;
            end
            nmode = M_OFFER;
        end else if (m_mode == M_OFFER) begin
            if (attendant_ack) begin
                nmode = M_SERV;
                m_rr  = (m_seat + 1) % NUM_SEATS;
            end else if (!nl[m_seat]) begin
                nmode = M_IDLE;
            end
        end else if (m_mode == M_SERV && attendant_done) begin
            nmode = M_IDLE;
        end
        m_age   = (m_mode == M_OFFER && nmode == M_OFFER) ? m_age + 1 : 0;
        m_esc   = ESC_ON && (nmode == M_OFFER) && (m_age >= ESCALATE_CYCLES);
        m_mode  = nmode;
        m_light = nl;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NUM_SEATS-1:0] call, input logic [NUM_SEATS-1:0] cancel,
                         input logic ack, input logic done);
        call_button    = call;
        cancel_button  = cancel;
        attendant_ack  = ack;
        attendant_done = done;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive('0, '0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive('1, '0, 1'b0, 1'b0);
        tick();
        exp = {8'h00, 2'b00, 3'd0, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_zero got %h want %h", obs, exp); end
        reset = 1'b0;
        tick();
        exp = {8'hFF, 2'b00, 3'd0, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_release got %h want %h", obs, exp); end
        drive('0, '0, 1'b0, 1'b0);
        tick();
        exp = {8'hFF, 2'b10, 3'd0, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_first_offer got %h want %h", obs, exp); end
        reset = 1'b1;
        drive('1, '0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        drive('0, '0, 1'b0, 1'b0);
        tick();
        exp = {8'h00, 2'b00, 3'd0, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_mid_offer got %h want %h", obs, exp); end
    endtask

    task automatic test_round_robin();
        logic [NUM_SEATS-1:0] lights [4] = '{8'hA0, 8'h84, 8'h04, 8'h00};
        int                   order  [4] = '{2, 5, 7, 2};
        do_reset();
        drive(8'hA4, '0, 1'b0, 1'b0);
        tick();
        exp = {8'hA4, 2'b00, 3'd0, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL rr_lights got %h want %h", obs, exp); end
        drive('0, '0, 1'b0, 1'b0);
        tick();
        for (int s = 0; s < 4; s++) begin
            // Seat 2 calls again in the idle cycle after its first service.
            exp = {(s == 1) ? 8'hA4 : lights[s] | ((s == 0) ? 8'hA4 : lights[s - 1]),
                   2'b10, 3'(order[s]), 1'b0};
            if (s == 0) exp[OBS_W-1 -: NUM_SEATS] = 8'hA4;
            if (s == 2) exp[OBS_W-1 -: NUM_SEATS] = 8'h84;
            if (s == 3) exp[OBS_W-1 -: NUM_SEATS] = 8'h04;
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL rr_offer%0d got %h want %h", s, obs, exp); end
            drive('0, '0, 1'b1, 1'b0);
            tick();
            drive('0, '0, 1'b0, 1'b1);
            tick();
            exp = {lights[s], 2'b00, 3'(order[s]), 1'b0};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL rr_done%0d got %h want %h", s, obs, exp); end
            drive((s == 0) ? 8'h04 : 8'h00, '0, 1'b0, 1'b0);
            tick();
            drive('0, '0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_cancel_offer();
        do_reset();
        drive(8'h08, '0, 1'b0, 1'b0);
        tick();
        drive('0, '0, 1'b0, 1'b0);
        tick();
        exp = {8'h08, 2'b10, 3'd3, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL cancel_offer3 got %h want %h", obs, exp); end
        drive('0, 8'h08, 1'b0, 1'b0);
        tick();
        exp = {8'h00, 2'b00, 3'd3, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL cancel_withdraw got %h want %h", obs, exp); end
        drive(8'h22, '0, 1'b0, 1'b0);
        tick();
        drive('0, '0, 1'b0, 1'b0);
        tick();
        // Pointer still at 0, so seat 1 precedes seat 5.
        exp = {8'h22, 2'b10, 3'd1, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL cancel_rr_kept got %h want %h", obs, exp); end
    endtask

    task automatic test_ack_cancel();
        do_reset();
        drive(8'h10, '0, 1'b0, 1'b0);
        tick();
        drive('0, '0, 1'b0, 1'b0);
        tick();
        drive('0, 8'h10, 1'b1, 1'b0);
        tick();
        exp = {8'h00, 2'b01, 3'd4, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL ackcancel_busy got %h want %h", obs, exp); end
        drive('0, '0, 1'b0, 1'b1);
        tick();
        exp = {8'h00, 2'b00, 3'd4, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL ackcancel_done got %h want %h", obs, exp); end
        drive('0, '0, 1'b1, 1'b1);
        tick();
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL stray_ack_idle got %h want %h", obs, exp); end
    endtask

    task automatic test_done_recall();
        do_reset();
        drive(8'h42, '0, 1'b0, 1'b0);
        tick();
        drive('0, '0, 1'b0, 1'b0);
        tick();
        drive('0, '0, 1'b1, 1'b0);
        tick();
        exp = {8'h42, 2'b01, 3'd1, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL recall_busy1 got %h want %h", obs, exp); end
        drive(8'h02, '0, 1'b0, 1'b1);
        tick();
        exp = {8'h42, 2'b00, 3'd1, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL recall_light_kept got %h want %h", obs, exp); end
        drive('0, '0, 1'b0, 1'b0);
        tick();
        exp = {8'h42, 2'b10, 3'd6, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL recall_other_first got %h want %h", obs, exp); end
        drive('0, '0, 1'b1, 1'b0);
        tick();
        drive('0, '0, 1'b0, 1'b1);
        tick();
        drive('0, '0, 1'b0, 1'b0);
        tick();
        exp = {8'h02, 2'b10, 3'd1, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL recall_reoffer got %h want %h", obs, exp); end
    endtask

    task automatic test_escalate();
        do_reset();
        drive(8'h01, '0, 1'b0, 1'b0);
        tick();
        drive('0, '0, 1'b0, 1'b0);
        tick();
        for (int k = 0; k <= 5; k++) begin
            exp = {8'h01, 2'b10, 3'd0, 1'(ESC_ON && (k >= ESCALATE_CYCLES))};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL escalate_k%0d got %h want %h", k, obs, exp); end
            tick();
        end
        drive('0, '0, 1'b1, 1'b0);
        tick();
        exp = {8'h01, 2'b01, 3'd0, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL escalate_ack_clear got %h want %h", obs, exp); end
        drive('0, '0, 1'b0, 1'b1);
        tick();
        exp = {8'h00, 2'b00, 3'd0, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL escalate_done got %h want %h", obs, exp); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 249) == 0);
            for (int i = 0; i < NUM_SEATS; i++) begin
                call_button[i]   = ($urandom_range(0, 11) == 0);
                cancel_button[i] = ($urandom_range(0, 11) == 0);
            end
            attendant_ack  = ($urandom_range(0, 3) == 0);
            attendant_done = ($urandom_range(0, 2) == 0);
            tick();
            exp = {m_light, m_mode == M_OFFER, m_mode == M_SERV, IDX_W'(m_seat), m_esc};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random_cycle%0d got %h want %h", n, obs, exp);
            end
            checks++;
            if (busy && dispatch_valid) begin
                errors++;
                $display("FAIL random_exclusive%0d got busy=1 valid=1 want not both", n);
            end
        end
        reset = 1'b0;
        drive('0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        drive('0, '0, 1'b0, 1'b0);
        test_reset();
        test_round_robin();
        test_cancel_offer();
        test_ack_cancel();
        test_done_recall();
        test_escalate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
